// File: rtl/bldc_commutator.sv
`default_nettype none
// ============================================================================
//  Module      : bldc_commutator
//  Description : Six-step BLDC commutation controller. Synchronises and
//                debounces three hall sensors, maps the accepted hall code to
//                per-phase drive codes, slew-limits the duty and sequences
//                direction reversal, braking and hall-fault recovery.
//  Revision    : 1.0  initial release
// ============================================================================
module bldc_commutator #(
    parameter int FILT_CYCLES = 4,
    parameter int RAMP_DIV    = 64,
    parameter int RAMP_STEP   = 8,
    parameter int BRAKE_DUTY  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        dir,
    input  logic        brake_req,
    input  logic        clr_err,
    input  logic        hallGrn,
    input  logic        hallYlw,
    input  logic        hallBlu,
    input  logic [10:0] duty_cmd,
    output logic [1:0]  selGrn,
    output logic [1:0]  selYlw,
    output logic [1:0]  selBlu,
    output logic [10:0] duty,
    output logic        hall_err,
    output logic        seq_err
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_RUN    = 3'd1;
    localparam logic [2:0] c_ST_DIRCHG = 3'd2;
    localparam logic [2:0] c_ST_BRAKE  = 3'd3;
    localparam logic [2:0] c_ST_FAULT  = 3'd4;

    localparam int              c_PW       = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [c_PW-1:0] c_DIV_LAST = c_PW'(RAMP_DIV - 1);
    localparam logic [3:0]      c_FILT     = 4'(FILT_CYCLES);
    localparam logic [11:0]     c_STEP     = 12'(RAMP_STEP);
    localparam logic [10:0]     c_BRAKE    = 11'(BRAKE_DUTY);

    // Position of a hall code in the forward rotation; 7 marks an invalid code.
    function automatic logic [2:0] seq_pos(input logic [2:0] code);
        logic [2:0] p;
        case (code)
            3'b101:  p = 3'd0;
            3'b100:  p = 3'd1;
            3'b110:  p = 3'd2;
            3'b010:  p = 3'd3;
            3'b011:  p = 3'd4;
            3'b001:  p = 3'd5;
            default: p = 3'd7;
        endcase
        return p;
    endfunction

    function automatic logic is_valid(input logic [2:0] code);
        return (code != 3'b000) && (code != 3'b111);
    endfunction

    // Neighbours in the six-step ring, including the wrap from last to first.
    function automatic logic is_adjacent(input logic [2:0] a, input logic [2:0] b);
        logic [2:0] pa;
        logic [2:0] pb;
        logic [2:0] d;
        pa = seq_pos(a);
        pb = seq_pos(b);
        d  = (pa > pb) ? (pa - pb) : (pb - pa);
        return (d == 3'd1) || (d == 3'd5);
    endfunction

    // {Grn, Ylw, Blu} drive codes; reverse rotation swaps FORWARD and REVERSE.
    function automatic logic [5:0] phase_pattern(input logic [2:0] code, input logic rev);
        logic [5:0] p;
        case (code)
            3'b101:  p = 6'b01_10_00;
            3'b100:  p = 6'b01_00_10;
            3'b110:  p = 6'b00_01_10;
            3'b010:  p = 6'b10_01_00;
            3'b011:  p = 6'b10_00_01;
            3'b001:  p = 6'b00_10_01;
            default: p = 6'b00_00_00;
        endcase
        if (rev) begin
            p = {p[4], p[5], p[2], p[3], p[0], p[1]};
        end
        return p;
    endfunction

    // One slew step toward the target, clamped so the target is never crossed.
    function automatic logic [10:0] ramp_toward(input logic [10:0] cur, input logic [10:0] tgt,
                                                input logic step_en);
        logic [11:0] gap;
        logic [10:0] res;
        res = cur;
        gap = 12'd0;
        if (step_en && (cur < tgt)) begin
            gap = {1'b0, tgt} - {1'b0, cur};
            res = (gap > c_STEP) ? (cur + c_STEP[10:0]) : tgt;
        end else if (step_en && (cur > tgt)) begin
            gap = {1'b0, cur} - {1'b0, tgt};
            res = (gap > c_STEP) ? (cur - c_STEP[10:0]) : tgt;
        end
        return res;
    endfunction

    logic [2:0]      r_sync1;
    logic [2:0]      r_sync2;
    logic [2:0]      r_cand;
    logic [3:0]      r_cnt;
    logic [2:0]      r_h;
    logic [c_PW-1:0] r_presc;
    logic [2:0]      r_state;
    logic            r_dir_act;
    logic [5:0]      r_sel;
    logic [10:0]     r_duty;
    logic            r_hall_err;
    logic            r_seq_err;

    logic [3:0]  w_run_len;
    logic        w_accept;
    logic        w_seq_bad;
    logic        w_tick;
    logic        w_h_ok;
    logic [2:0]  w_state_next;
    logic        w_dir_next;
    logic [5:0]  w_pattern;
    logic [5:0]  w_sel_next;
    logic [10:0] w_duty_next;
    logic        w_hall_err_next;

    // Two-flop synchroniser for the asynchronous hall inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
        end else begin
            r_sync1 <= {hallGrn, hallYlw, hallBlu};
            r_sync2 <= r_sync1;
        end
    end

    // Run length of the current synced code and the acceptance strobe.
    always_comb begin
        if (r_sync2 != r_cand) begin
            w_run_len = 4'd1;
        end else if (r_cnt >= c_FILT) begin
            w_run_len = r_cnt;
        end else begin
            w_run_len = r_cnt + 4'd1;
        end
        w_accept  = (w_run_len == c_FILT) && (r_sync2 != r_h);
        w_seq_bad = (r_state == c_ST_RUN) && w_accept && is_valid(r_sync2) &&
                    is_valid(r_h) && !is_adjacent(r_h, r_sync2);
    end

    // Debounce filter: a code is accepted after FILT_CYCLES equal samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cand <= 3'b000;
            r_cnt  <= 4'd0;
            r_h    <= 3'b000;
        end else begin
            r_cand <= r_sync2;
            r_cnt  <= w_run_len;
            if (w_accept) begin
                r_h <= r_sync2;
            end
        end
    end

    assign w_tick = (r_presc == c_DIV_LAST);
    assign w_h_ok = is_valid(r_h);

    // Free-running prescaler that paces the duty ramp.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
        end else begin
            r_presc <= w_tick ? '0 : (r_presc + c_PW'(1));
        end
    end

    // Next state, then outputs derived from the destination state.
    always_comb begin
        w_state_next    = r_state;
        w_dir_next      = r_dir_act;
        w_sel_next      = 6'b00_00_00;
        w_duty_next     = 11'd0;
        w_hall_err_next = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (en && w_h_ok) begin
                    w_state_next = c_ST_RUN;
                    w_dir_next   = dir;
                end
            end
            c_ST_RUN: begin
                if (!en)                    w_state_next = c_ST_IDLE;
                else if (!w_h_ok)           w_state_next = c_ST_FAULT;
                else if (brake_req)         w_state_next = c_ST_BRAKE;
                else if (dir != r_dir_act)  w_state_next = c_ST_DIRCHG;
            end
            c_ST_DIRCHG: begin
                if (!en)                    w_state_next = c_ST_IDLE;
                else if (!w_h_ok)           w_state_next = c_ST_FAULT;
                else if (brake_req)         w_state_next = c_ST_BRAKE;
                else if (r_duty == 11'd0) begin
                    w_state_next = c_ST_RUN;
                    w_dir_next   = dir;
                end else if (dir == r_dir_act) begin
                    w_state_next = c_ST_RUN;
                end
            end
            c_ST_BRAKE: begin
                if (!brake_req) begin
                    w_dir_next   = dir;
                    w_state_next = (en && w_h_ok) ? c_ST_RUN : c_ST_IDLE;
                end
            end
            c_ST_FAULT: begin
                if (clr_err && w_h_ok) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase

        w_pattern = phase_pattern(r_h, w_dir_next);
        case (w_state_next)
            c_ST_RUN: begin
                w_sel_next = w_pattern;
                // Entry from IDLE or BRAKE restarts the ramp from zero.
                if ((r_state == c_ST_RUN) || (r_state == c_ST_DIRCHG)) begin
                    w_duty_next = ramp_toward(r_duty, duty_cmd, w_tick);
                end
            end
            c_ST_DIRCHG: begin
                w_sel_next  = w_pattern;
                w_duty_next = ramp_toward(r_duty, 11'd0, w_tick);
            end
            c_ST_BRAKE: begin
                w_sel_next  = 6'b11_11_11;
                w_duty_next = c_BRAKE;
            end
            c_ST_FAULT: begin
                w_hall_err_next = 1'b1;
            end
            default: begin
                w_sel_next = 6'b00_00_00;
            end
        endcase
    end

    // State, direction and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_dir_act  <= 1'b0;
            r_sel      <= 6'b00_00_00;
            r_duty     <= 11'd0;
            r_hall_err <= 1'b0;
            r_seq_err  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_dir_act  <= w_dir_next;
            r_sel      <= w_sel_next;
            r_duty     <= w_duty_next;
            r_hall_err <= w_hall_err_next;
            r_seq_err  <= w_seq_bad;
        end
    end

    assign selGrn   = r_sel[5:4];
    assign selYlw   = r_sel[3:2];
    assign selBlu   = r_sel[1:0];
    assign duty     = r_duty;
    assign hall_err = r_hall_err;
    assign seq_err  = r_seq_err;

endmodule
`default_nettype wire

// File: tb/tb_bldc_commutator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bldc_commutator
//  Description : Directed bench for bldc_commutator with a cycle-level
//                behavioural reference and hand-computed checkpoints.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bldc_commutator;

    localparam int F    = 4;
    localparam int DIV  = 64;
    localparam int STEP = 8;
    localparam int BRK  = 1024;

    localparam logic [2:0] M_IDLE   = 3'd0;
    localparam logic [2:0] M_RUN    = 3'd1;
    localparam logic [2:0] M_DIRCHG = 3'd2;
    localparam logic [2:0] M_BRAKE  = 3'd3;
    localparam logic [2:0] M_FAULT  = 3'd4;

    logic        clk;
    logic        rst;
    logic        en;
    logic        dir;
    logic        brake_req;
    logic        clr_err;
    logic [2:0]  halls;
    logic [10:0] duty_cmd;
    logic [1:0]  selGrn;
    logic [1:0]  selYlw;
    logic [1:0]  selBlu;
    logic [10:0] duty;
    logic        hall_err;
    logic        seq_err;

    logic [5:0]  sel6;
    assign sel6 = {selGrn, selYlw, selBlu};

    int n_cmp = 0;
    int n_bad = 0;
    int seq_cnt = 0;

    bldc_commutator #(
        .FILT_CYCLES (F),
        .RAMP_DIV    (DIV),
        .RAMP_STEP   (STEP),
        .BRAKE_DUTY  (BRK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .dir       (dir),
        .brake_req (brake_req),
        .clr_err   (clr_err),
        .hallGrn   (halls[2]),
        .hallYlw   (halls[1]),
        .hallBlu   (halls[0]),
        .duty_cmd  (duty_cmd),
        .selGrn    (selGrn),
        .selYlw    (selYlw),
        .selBlu    (selBlu),
        .duty      (duty),
        .hall_err  (hall_err),
        .seq_err   (seq_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference ----------------
    typedef struct packed {
        logic [2:0]  st;
        logic        dir;
        logic [10:0] duty;
        logic [6:0]  presc;
        logic [2:0]  h;
        logic [5:0]  sel;
        logic        herr;
        logic        serr;
    } mstate_t;

    mstate_t    m;
    logic [2:0] m_hist [0:15];   // m_hist[k] = hall input sampled k+1 edges ago

    function automatic int code_pos(input logic [2:0] code);
        logic [2:0] ring [0:5];
        ring[0] = 3'b101; ring[1] = 3'b100; ring[2] = 3'b110;
        ring[3] = 3'b010; ring[4] = 3'b011; ring[5] = 3'b001;
        for (int i = 0; i < 6; i++) if (ring[i] == code) return i;
        return -1;
    endfunction

    function automatic logic [5:0] drive_for(input logic [2:0] code, input logic rev);
        logic [5:0] tbl [0:5];
        logic [5:0] p;
        int pos;
        int v;
        tbl[0] = 6'b011000; tbl[1] = 6'b010010; tbl[2] = 6'b000110;
        tbl[3] = 6'b100100; tbl[4] = 6'b100001; tbl[5] = 6'b001001;
        pos = code_pos(code);
        if (pos < 0) return 6'b0;
        p = tbl[pos];
        if (rev) begin
            for (int k = 0; k < 3; k++) begin
                v = int'(p[2*k +: 2]);
                if (v == 1) p[2*k +: 2] = 2'd2;
                else if (v == 2) p[2*k +: 2] = 2'd1;
            end
        end
        return p;
    endfunction

    function automatic logic [10:0] approach(input int cur, input int tgt, input bit step);
        int r;
        r = cur;
        if (step) begin
            if (tgt - cur > STEP)      r = cur + STEP;
            else if (cur - tgt > STEP) r = cur - STEP;
            else                       r = tgt;
        end
        return 11'(r);
    endfunction

    function automatic mstate_t model_next(input mstate_t c);
        mstate_t    n;
        logic [2:0] cand;
        bit         stable;
        bit         accept;
        bit         hok;
        bit         tick;
        int         d;
        n      = c;
        cand   = m_hist[1];
        stable = 1'b1;
        for (int i = 2; i <= F; i++) if (m_hist[i] != cand) stable = 1'b0;
        accept = stable && (cand != c.h);
        hok    = code_pos(c.h) >= 0;
        tick   = (int'(c.presc) == DIV - 1);
        n.presc = 7'((int'(c.presc) + 1) % DIV);
        d = (code_pos(c.h) - code_pos(cand) + 6) % 6;
        n.serr = (c.st == M_RUN) && accept && (code_pos(cand) >= 0) && hok && (d != 1) && (d != 5);
        n.h    = accept ? cand : c.h;
        case (c.st)
            M_IDLE:   if (en && hok) begin n.st = M_RUN; n.dir = dir; end
            M_RUN: begin
                if (!en)              n.st = M_IDLE;
                else if (!hok)        n.st = M_FAULT;
                else if (brake_req)   n.st = M_BRAKE;
                else if (dir != c.dir) n.st = M_DIRCHG;
            end
            M_DIRCHG: begin
                if (!en)               n.st = M_IDLE;
                else if (!hok)         n.st = M_FAULT;
                else if (brake_req)    n.st = M_BRAKE;
                else if (c.duty == 0)  begin n.st = M_RUN; n.dir = dir; end
                else if (dir == c.dir) n.st = M_RUN;
            end
            M_BRAKE:  if (!brake_req) begin n.dir = dir; n.st = (en && hok) ? M_RUN : M_IDLE; end
            default:  if (clr_err && hok) n.st = M_IDLE;
        endcase
        n.sel  = 6'b0;
        n.duty = 11'd0;
        n.herr = 1'b0;
        case (n.st)
            M_RUN: begin
                n.sel = drive_for(c.h, n.dir);
                if (c.st == M_RUN || c.st == M_DIRCHG)
                    n.duty = approach(int'(c.duty), int'(duty_cmd), tick);
            end
            M_DIRCHG: begin
                n.sel  = drive_for(c.h, n.dir);
                n.duty = approach(int'(c.duty), 0, tick);
            end
            M_BRAKE: begin
                n.sel  = 6'b111111;
                n.duty = 11'(BRK);
            end
            M_FAULT: n.herr = 1'b1;
            default: n.sel = 6'b0;
        endcase
        return n;
    endfunction

    // Reference advances on the same edges as the design.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m <= '0;
            for (int i = 0; i < 16; i++) m_hist[i] <= 3'b000;
        end else begin
            m <= model_next(m);
            for (int i = 15; i > 0; i--) m_hist[i] <= m_hist[i-1];
            m_hist[0] <= halls;
        end
    end

    // Every cycle: all outputs against the reference, mid-cycle.
    always @(negedge clk) begin
        check("cycle outputs {sel,duty,hall_err,seq_err}",
              {13'd0, sel6, duty, hall_err, seq_err},
              {13'd0, m.sel, m.duty, m.herr, m.serr});
    end

    always @(negedge clk) begin
        if (seq_err) seq_cnt <= seq_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int base;
        rst = 1'b1; en = 1'b1; dir = 1'b0; brake_req = 1'b0; clr_err = 1'b0;
        halls = 3'b101; duty_cmd = 11'd40;
        cycles(3);
        check("reset sel", {26'd0, sel6}, 32'd0);
        check("reset duty", {21'd0, duty}, 32'd0);
        check("reset flags", {30'd0, hall_err, seq_err}, 32'd0);
        rst = 1'b0;

        // Start-up: first commutation exactly 7 clocks after release
        cycles(6);
        check("sel before acceptance", {26'd0, sel6}, 32'd0);
        cycles(1);
        check("first commutation 101", {26'd0, sel6}, 32'h18);
        cycles(56);
        check("duty before first ramp tick", {21'd0, duty}, 32'd0);
        cycles(1);
        check("duty first step", {21'd0, duty}, 32'd8);
        cycles(256);
        check("duty reaches target", {21'd0, duty}, 32'd40);
        cycles(64);
        check("duty holds at target", {21'd0, duty}, 32'd40);

        // Hall stepping in the forward order
        base = seq_cnt;
        halls = 3'b100;
        cycles(6);
        check("sel unchanged at 6 clocks", {26'd0, sel6}, 32'h18);
        cycles(1);
        check("sel for 100", {26'd0, sel6}, 32'h12);
        cycles(13);
        halls = 3'b110;
        cycles(7);
        check("sel for 110", {26'd0, sel6}, 32'h06);
        cycles(13);
        halls = 3'b010;
        cycles(2);
        halls = 3'b110;
        cycles(10);
        check("glitch ignored", {26'd0, sel6}, 32'h06);
        halls = 3'b100;
        cycles(20);
        halls = 3'b101;
        cycles(20);
        check("back at 101", {26'd0, sel6}, 32'h18);
        check("no seq_err in order", seq_cnt - base, 32'd0);
        base = seq_cnt;
        halls = 3'b010;
        cycles(20);
        check("seq_err single pulse on jump", seq_cnt - base, 32'd1);
        check("sel for 010", {26'd0, sel6}, 32'h24);
        halls = 3'b101;
        cycles(20);

        // Direction change: drain, flip, ramp back
        dir = 1'b1;
        for (int i = 0; i < 400 && duty != 11'd0; i++) @(negedge clk);
        check("dirchg drains to 0", {21'd0, duty}, 32'd0);
        check("dirchg keeps forward pattern", {26'd0, sel6}, 32'h18);
        cycles(1);
        check("reverse pattern for 101", {26'd0, sel6}, 32'h24);
        for (int i = 0; i < 400 && duty != 11'd40; i++) @(negedge clk);
        check("duty back to 40 reversed", {21'd0, duty}, 32'd40);

        // Direction request withdrawn mid-drain
        dir = 1'b0;
        for (int i = 0; i < 100 && duty != 11'd32; i++) @(negedge clk);
        check("partial drain to 32", {21'd0, duty}, 32'd32);
        dir = 1'b1;
        for (int i = 0; i < 200 && duty != 11'd40; i++) @(negedge clk);
        check("resume from current duty", {21'd0, duty}, 32'd40);
        check("direction kept after abort", {26'd0, sel6}, 32'h24);

        // Brake
        brake_req = 1'b1;
        cycles(1);
        check("brake sel", {26'd0, sel6}, 32'h3f);
        check("brake duty", {21'd0, duty}, 32'd1024);
        cycles(5);
        brake_req = 1'b0;
        cycles(1);
        check("brake release duty", {21'd0, duty}, 32'd0);
        check("brake release sel", {26'd0, sel6}, 32'h24);

        // Enable drop
        cycles(3);
        en = 1'b0;
        cycles(1);
        check("disable sel", {26'd0, sel6}, 32'd0);
        en = 1'b1;
        cycles(1);
        check("re-enable sel", {26'd0, sel6}, 32'h24);

        // Hall fault
        halls = 3'b111;
        cycles(6);
        check("no fault yet", {31'd0, hall_err}, 32'd0);
        cycles(1);
        check("fault hall_err", {31'd0, hall_err}, 32'd1);
        check("fault sel/duty", {15'd0, sel6, duty}, 32'd0);
        clr_err = 1'b1;
        cycles(3);
        clr_err = 1'b0;
        check("clr with invalid halls ignored", {31'd0, hall_err}, 32'd1);
        halls = 3'b101;
        cycles(8);
        check("fault held until clr", {31'd0, hall_err}, 32'd1);
        clr_err = 1'b1;
        cycles(1);
        check("clr exits fault", {31'd0, hall_err}, 32'd0);
        check("idle after clr", {26'd0, sel6}, 32'd0);
        clr_err = 1'b0;
        cycles(1);
        check("run after idle", {26'd0, sel6}, 32'h24);

        // Asynchronous reset mid-ramp
        duty_cmd = 11'd200;
        for (int i = 0; i < 400 && duty < 11'd24; i++) @(negedge clk);
        check("ramping before reset", {31'd0, duty >= 11'd24}, 32'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async reset outputs", {13'd0, sel6, duty, hall_err, seq_err}, 32'd0);
        cycles(3);
        rst = 1'b0;
        cycles(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
